// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- two-entry skid register between the id and ex stages.
//
// The main register drives out_data directly. The skid register catches the
// entry that arrives in the same cycle downstream stalls, so in_ready can be
// a flop rather than a combinational path from out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   flush      synchronous kill of all held entries and of any concurrent input
//   in_valid   upstream entry valid
//   in_ready   registered; equals !skid_valid
//   in_data    upstream payload (DATA_W)
//   out_valid  downstream entry valid
//   out_ready  downstream consumes the entry this cycle
//   out_data   registered payload; NOP_VALUE whenever out_valid is 0
//   occ        number of held entries, 0..2
//   stall_cnt  cycles with out_valid && !out_ready (PIPE_PERF_CNT_EN only)
//   bubble_cnt cycles with !out_valid (PIPE_PERF_CNT_EN only)
//
// Optional feature macro: PIPE_PERF_CNT_EN adds the two saturating counters.
// Reset clears them; flush does not.

module pipe_skid_reg #(
  parameter int unsigned          DATA_W    = 81,
  parameter logic [DATA_W-1:0]    NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign occ       = state_q;

  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d  = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          // Park the bubble value so out_data reads NOP while empty.
          main_d  = NOP_VALUE;
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so in_fire cannot occur.
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = NOP_VALUE;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = NOP_VALUE;
        skid_d  = NOP_VALUE;
      end
    endcase
    // Flush overrides the handshake update and drops any concurrent input.
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= NOP_VALUE;
      skid_q     <= NOP_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counters look at the pre-edge state, so flush cycles are counted too.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;
  localparam int unsigned       DATA_W = 81;
  localparam logic [DATA_W-1:0] NOP    = '0;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  int pass_cnt = 0;
  int total    = 0;
  logic [DATA_W-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DATA_W), .NOP_VALUE(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // One clock with the currently driven inputs. Transfers are judged from
  // the values present before the edge; the scoreboard pops on every
  // output transfer and pushes on every accepted input, then the post-edge
  // state is checked against the queue.
  task automatic tick();
    logic ifire, ofire;
    logic [DATA_W-1:0] exp;
    ifire = (in_valid === 1'b1) && (in_ready === 1'b1);
    ofire = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (ofire) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL sb_pop_empty: out_data=%0h with nothing expected", out_data);
      else begin
        exp = sb.pop_front();
        if (out_data !== exp)
          $display("FAIL sb_data: got %0h expected %0h", out_data, exp);
        else pass_cnt++;
      end
    end
    if (rst === 1'b0 || flush === 1'b1) sb.delete();
    else if (ifire) sb.push_back(in_data);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (occ !== 2'(sb.size()) || out_valid !== (sb.size() != 0) ||
        in_ready !== (sb.size() < 2))
      $display("FAIL state: occ=%0d out_valid=%b in_ready=%b expected occ=%0d",
               occ, out_valid, in_ready, sb.size());
    else pass_cnt++;
    total++;
    if (sb.size() == 0 ? (out_data !== NOP) : (out_data !== sb[0]))
      $display("FAIL head: out_data=%0h expected %0h", out_data,
               sb.size() == 0 ? NOP : sb[0]);
    else pass_cnt++;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_data = NOP;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (out_valid !== 1'b0 || out_data !== NOP || occ !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL reset: out_valid=%b out_data=%0h occ=%0d in_ready=%b required 0,0,0,1",
               out_valid, out_data, occ, in_ready);
    else pass_cnt++;
`ifdef PIPE_PERF_CNT_EN
    total++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0)
      $display("FAIL reset_cnt: stall=%0d bubble=%0d required 0,0", stall_cnt, bubble_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = DATA_W'(1); out_ready = 1'b1;
    tick();
    idle();
    total++;
    if (out_valid !== 1'b1 || out_data !== DATA_W'(1) || occ !== 2'd1)
      $display("FAIL single: out_valid=%b out_data=%0h occ=%0d required 1,1,1",
               out_valid, out_data, occ);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i);
      tick();
      total++;
      if (out_data !== DATA_W'(i) || in_ready !== 1'b1)
        $display("FAIL stream%0d: out_data=%0h in_ready=%b required %0h,1",
                 i, out_data, in_ready, i);
      else pass_cnt++;
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'('hA); tick();
    in_data = DATA_W'('hB); tick();
    total++;
    if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== DATA_W'('hA))
      $display("FAIL bp_full: occ=%0d in_ready=%b out_data=%0h required 2,0,a",
               occ, in_ready, out_data);
    else pass_cnt++;
    in_data = DATA_W'('hC); tick();
    tick();
    total++;
    if (out_data !== DATA_W'('hA) || occ !== 2'd2)
      $display("FAIL bp_hold: out_data=%0h occ=%0d required a,2", out_data, occ);
    else pass_cnt++;
    idle(); out_ready = 1'b1;
    tick();
    total++;
    if (out_data !== DATA_W'('hB) || in_ready !== 1'b1)
      $display("FAIL bp_drain1: out_data=%0h in_ready=%b required b,1", out_data, in_ready);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== NOP)
      $display("FAIL bp_drain2: out_valid=%b out_data=%0h required 0,0", out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'('h11); tick();
    in_data = DATA_W'('h22); tick();
    flush = 1'b1; in_data = DATA_W'('hD); tick();
    idle();
    total++;
    if (out_valid !== 1'b0 || out_data !== NOP || occ !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL flush: out_valid=%b out_data=%0h occ=%0d in_ready=%b required 0,0,0,1",
               out_valid, out_data, occ, in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (2) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data === DATA_W'('hD))
        $display("FAIL flush_leak: out_valid=%b out_data=%0h required 0,0", out_valid, out_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'('h33); tick();
    in_data = DATA_W'('h44); tick();
    rst = 1'b0; in_data = DATA_W'('h55); tick();
    rst = 1'b1; idle();
    total++;
    if (out_valid !== 1'b0 || out_data !== NOP || occ !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL rst_mid: out_valid=%b out_data=%0h occ=%0d in_ready=%b required 0,0,0,1",
               out_valid, out_data, occ, in_ready);
    else pass_cnt++;
    out_ready = 1'b1; in_valid = 1'b1; in_data = DATA_W'(5); tick();
    idle();
    total++;
    if (out_valid !== 1'b1 || out_data !== DATA_W'(5))
      $display("FAIL rst_latency: out_valid=%b out_data=%0h required 1,5", out_valid, out_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 40) == 0);
      in_data   = DATA_W'({$urandom, $urandom});
      tick();
    end
    idle(); out_ready = 1'b1;
    repeat (3) tick();
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] s0, b0;
    idle(); out_ready = 1'b1; tick();
    s0 = stall_cnt; b0 = bubble_cnt;
    out_ready = 1'b0; in_valid = 1'b1; in_data = DATA_W'('h77); tick();
    idle();
    repeat (5) tick();
    out_ready = 1'b1; tick();
    repeat (3) tick();
    total++;
    if (stall_cnt - s0 !== 32'd5 || bubble_cnt - b0 !== 32'd4)
      $display("FAIL perf: stall_delta=%0d bubble_delta=%0d required 5,4",
               stall_cnt - s0, bubble_cnt - b0);
    else pass_cnt++;
    flush = 1'b1; tick();
    flush = 1'b0;
    total++;
    if (stall_cnt - s0 !== 32'd5 || bubble_cnt - b0 !== 32'd5)
      $display("FAIL perf_flush: stall_delta=%0d bubble_delta=%0d required 5,5",
               stall_cnt - s0, bubble_cnt - b0);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
